// File: rtl/bf_core.sv
// ---------------------------------------------------------------------------
// bf_core
//   Hardware interpreter for the eight-instruction tape language
//   ('+', '-', '>', '<', '.', ',', '[', ']').
//
//   The program is written into an internal instruction memory while the
//   core is not running. A single-cycle start clears the tape and runs the
//   program. Output ('.') and input (',') each stall on a valid/ready
//   handshake. Bracket jumps are resolved by walking the program one
//   instruction per cycle, with a bounded depth counter.
//
// Ports
//   clk                  : clock, all state on the rising edge
//   rst_n                : asynchronous active-low reset
//   prog_wr_en           : program memory write strobe (IDLE/HALT/ERR only)
//   prog_wr_addr         : program memory write address
//   prog_wr_data         : opcode 0 '+',1 '-',2 '>',3 '<',4 '.',5 ',',6 '[',7 ']'
//   prog_len             : instruction count, latched on start
//   start                : single-cycle run request (IDLE/HALT/ERR only)
//   machine_input        : input data word
//   machine_input_valid  : input data valid
//   machine_input_ready  : core waits for input (registered)
//   machine_output       : output data word (registered)
//   machine_output_valid : output data valid (registered)
//   machine_output_ready : sink accepts output
//   busy / halted / error: running / finished normally / finished on fault
// ---------------------------------------------------------------------------
module bf_core #(
  parameter int WORD_SIZE      = 8,
  parameter int TAPE_LENGTH    = 256,
  parameter int PROGRAM_LENGTH = 64,
  parameter int MAX_DEPTH      = 15
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              prog_wr_en,
  input  logic [$clog2(PROGRAM_LENGTH)-1:0] prog_wr_addr,
  input  logic [2:0]                        prog_wr_data,
  input  logic [$clog2(PROGRAM_LENGTH):0]   prog_len,
  input  logic                              start,
  input  logic [WORD_SIZE-1:0]              machine_input,
  input  logic                              machine_input_valid,
  output logic                              machine_input_ready,
  output logic [WORD_SIZE-1:0]              machine_output,
  output logic                              machine_output_valid,
  input  logic                              machine_output_ready,
  output logic                              busy,
  output logic                              halted,
  output logic                              error
);

  localparam int AW = $clog2(PROGRAM_LENGTH);
  localparam int PW = AW + 1;
  localparam int TW = $clog2(TAPE_LENGTH);
  localparam int DW = $clog2(MAX_DEPTH + 1);

  localparam logic [2:0] OP_INC   = 3'd0;
  localparam logic [2:0] OP_DEC   = 3'd1;
  localparam logic [2:0] OP_RIGHT = 3'd2;
  localparam logic [2:0] OP_LEFT  = 3'd3;
  localparam logic [2:0] OP_OUT   = 3'd4;
  localparam logic [2:0] OP_IN    = 3'd5;
  localparam logic [2:0] OP_JZ    = 3'd6;
  localparam logic [2:0] OP_JNZ   = 3'd7;

  localparam logic [WORD_SIZE-1:0] CELL_ONE  = WORD_SIZE'(1);
  localparam logic [PW-1:0]        PC_ONE    = PW'(1);
  localparam logic [PW-1:0]        PC_ZERO   = PW'(0);
  localparam logic [PW-1:0]        PROG_SIZE = PW'(PROGRAM_LENGTH);
  localparam logic [TW-1:0]        PTR_ONE   = TW'(1);
  localparam logic [TW-1:0]        PTR_ZERO  = TW'(0);
  localparam logic [TW-1:0]        PTR_LAST  = TW'(TAPE_LENGTH - 1);
  localparam logic [DW-1:0]        DEPTH_ONE = DW'(1);
  localparam logic [DW-1:0]        DEPTH_MAX = DW'(MAX_DEPTH);

  typedef enum logic [2:0] {
    IDLE, RUN, SEARCH_R, SEARCH_L, OUT, IN, HALT, ERR
  } state_t;

  state_t               state_r;
  logic [PW-1:0]        pc_r;
  logic [PW-1:0]        len_r;
  logic [TW-1:0]        ptr_r;
  logic [DW-1:0]        depth_r;
  logic [WORD_SIZE-1:0] tape_r [TAPE_LENGTH];
  logic [2:0]           prog_mem_r [PROGRAM_LENGTH];

  logic                 loadable_s;
  logic [WORD_SIZE-1:0] cur_cell_s;
  logic                 cell_zero_s;
  logic [2:0]           cur_op_s;
  logic [PW-1:0]        pc_inc_s;
  logic [PW-1:0]        pc_dec_s;
  logic                 pc_at_zero_s;
  logic                 pc_at_end_s;
  logic [TW-1:0]        ptr_inc_s;
  logic [TW-1:0]        ptr_dec_s;
  logic                 depth_full_s;
  logic                 depth_last_s;

  // Decode of the current cell, instruction and next pc/pointer values.
  always_comb begin
    loadable_s   = (state_r == IDLE) || (state_r == HALT) || (state_r == ERR);
    cur_cell_s   = tape_r[ptr_r];
    cell_zero_s  = (cur_cell_s == '0);
    cur_op_s     = prog_mem_r[pc_r[AW-1:0]];
    pc_inc_s     = pc_r + PC_ONE;
    pc_dec_s     = pc_r - PC_ONE;
    pc_at_zero_s = (pc_r == PC_ZERO);
    pc_at_end_s  = (pc_r == len_r);
    depth_full_s = (depth_r == DEPTH_MAX);
    depth_last_s = (depth_r == DEPTH_ONE);
    // Pointer wraps explicitly so non-power-of-two tape lengths work.
    if (ptr_r == PTR_LAST) begin
      ptr_inc_s = PTR_ZERO;
    end else begin
      ptr_inc_s = ptr_r + PTR_ONE;
    end
    if (ptr_r == PTR_ZERO) begin
      ptr_dec_s = PTR_LAST;
    end else begin
      ptr_dec_s = ptr_r - PTR_ONE;
    end
  end

  // Program memory write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (prog_wr_en && loadable_s && ({1'b0, prog_wr_addr} < PROG_SIZE)) begin
      prog_mem_r[prog_wr_addr] <= prog_wr_data;
    end
  end

  // Interpreter state machine, tape and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r              <= IDLE;
      pc_r                 <= '0;
      len_r                <= '0;
      ptr_r                <= '0;
      depth_r              <= '0;
      for (int i = 0; i < TAPE_LENGTH; i++) tape_r[i] <= '0;
      machine_input_ready  <= 1'b0;
      machine_output       <= '0;
      machine_output_valid <= 1'b0;
      busy                 <= 1'b0;
      halted               <= 1'b0;
      error                <= 1'b0;
    end else begin
      case (state_r)
        IDLE, HALT, ERR: begin
          if (start) begin
            for (int i = 0; i < TAPE_LENGTH; i++) tape_r[i] <= '0;
            pc_r    <= '0;
            ptr_r   <= '0;
            depth_r <= '0;
            len_r   <= prog_len;
            state_r <= RUN;
            busy    <= 1'b1;
            halted  <= 1'b0;
            error   <= 1'b0;
          end
        end

        RUN: begin
          if (pc_at_end_s) begin
            state_r <= HALT;
            busy    <= 1'b0;
            halted  <= 1'b1;
          end else begin
            case (cur_op_s)
              OP_INC: begin
                tape_r[ptr_r] <= cur_cell_s + CELL_ONE;
                pc_r          <= pc_inc_s;
              end
              OP_DEC: begin
                tape_r[ptr_r] <= cur_cell_s - CELL_ONE;
                pc_r          <= pc_inc_s;
              end
              OP_RIGHT: begin
                ptr_r <= ptr_inc_s;
                pc_r  <= pc_inc_s;
              end
              OP_LEFT: begin
                ptr_r <= ptr_dec_s;
                pc_r  <= pc_inc_s;
              end
              OP_OUT: begin
                machine_output       <= cur_cell_s;
                machine_output_valid <= 1'b1;
                state_r              <= OUT;
              end
              OP_IN: begin
                machine_input_ready <= 1'b1;
                state_r             <= IN;
              end
              OP_JZ: begin
                pc_r <= pc_inc_s;
                if (cell_zero_s) begin
                  depth_r <= DEPTH_ONE;
                  state_r <= SEARCH_R;
                end
              end
              OP_JNZ: begin
                if (cell_zero_s) begin
                  pc_r <= pc_inc_s;
                end else if (pc_at_zero_s) begin
                  // Backward search would have to start below address 0.
                  state_r <= ERR;
                  busy    <= 1'b0;
                  error   <= 1'b1;
                end else begin
                  depth_r <= DEPTH_ONE;
                  pc_r    <= pc_dec_s;
                  state_r <= SEARCH_L;
                end
              end
              default: begin
                pc_r <= pc_inc_s;
              end
            endcase
          end
        end

        SEARCH_R: begin
          if (pc_at_end_s) begin
            state_r <= ERR;
            busy    <= 1'b0;
            error   <= 1'b1;
          end else begin
            case (cur_op_s)
              OP_JZ: begin
                if (depth_full_s) begin
                  state_r <= ERR;
                  busy    <= 1'b0;
                  error   <= 1'b1;
                end else begin
                  depth_r <= depth_r + DEPTH_ONE;
                  pc_r    <= pc_inc_s;
                end
              end
              OP_JNZ: begin
                depth_r <= depth_r - DEPTH_ONE;
                pc_r    <= pc_inc_s;
                if (depth_last_s) begin
                  state_r <= RUN;
                end
              end
              default: begin
                pc_r <= pc_inc_s;
              end
            endcase
          end
        end

        SEARCH_L: begin
          case (cur_op_s)
            OP_JNZ: begin
              if (depth_full_s || pc_at_zero_s) begin
                state_r <= ERR;
                busy    <= 1'b0;
                error   <= 1'b1;
              end else begin
                depth_r <= depth_r + DEPTH_ONE;
                pc_r    <= pc_dec_s;
              end
            end
            OP_JZ: begin
              if (depth_last_s) begin
                // Matching '[' found: resume just after it.
                depth_r <= '0;
                pc_r    <= pc_inc_s;
                state_r <= RUN;
              end else if (pc_at_zero_s) begin
                state_r <= ERR;
                busy    <= 1'b0;
                error   <= 1'b1;
              end else begin
                depth_r <= depth_r - DEPTH_ONE;
                pc_r    <= pc_dec_s;
              end
            end
            default: begin
              if (pc_at_zero_s) begin
                state_r <= ERR;
                busy    <= 1'b0;
                error   <= 1'b1;
              end else begin
                pc_r <= pc_dec_s;
              end
            end
          endcase
        end

        OUT: begin
          if (machine_output_ready) begin
            machine_output_valid <= 1'b0;
            pc_r                 <= pc_inc_s;
            state_r              <= RUN;
          end
        end

        IN: begin
          if (machine_input_valid) begin
            tape_r[ptr_r]       <= machine_input;
            machine_input_ready <= 1'b0;
            pc_r                <= pc_inc_s;
            state_r             <= RUN;
          end
        end

        default: begin
          state_r              <= IDLE;
          machine_input_ready  <= 1'b0;
          machine_output_valid <= 1'b0;
          busy                 <= 1'b0;
          halted               <= 1'b0;
          error                <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bf_core.sv
// ---------------------------------------------------------------------------
// tb_bf_core
//   Directed self-checking bench for bf_core. The core is built with a
//   five-cell tape so pointer wrap is exercised on a non-power-of-two length.
// ---------------------------------------------------------------------------
module tb_bf_core;

  localparam int WS = 8;
  localparam int TL = 5;
  localparam int PL = 64;
  localparam int MD = 15;
  localparam int LIMIT = 300;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  prog_wr_en;
  logic [$clog2(PL)-1:0] prog_wr_addr;
  logic [2:0]            prog_wr_data;
  logic [$clog2(PL):0]   prog_len;
  logic                  start;
  logic [WS-1:0]         machine_input;
  logic                  machine_input_valid;
  logic                  machine_input_ready;
  logic [WS-1:0]         machine_output;
  logic                  machine_output_valid;
  logic                  machine_output_ready;
  logic                  busy;
  logic                  halted;
  logic                  error;

  int checks = 0;
  int errors = 0;
  int xfers  = 0;

  always #5 clk = ~clk;

  bf_core #(
    .WORD_SIZE(WS), .TAPE_LENGTH(TL), .PROGRAM_LENGTH(PL), .MAX_DEPTH(MD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .prog_wr_en(prog_wr_en), .prog_wr_addr(prog_wr_addr),
    .prog_wr_data(prog_wr_data), .prog_len(prog_len), .start(start),
    .machine_input(machine_input), .machine_input_valid(machine_input_valid),
    .machine_input_ready(machine_input_ready),
    .machine_output(machine_output), .machine_output_valid(machine_output_valid),
    .machine_output_ready(machine_output_ready),
    .busy(busy), .halted(halted), .error(error)
  );

  // Counts completed output handshakes.
  always @(posedge clk) begin
    if (rst_n && machine_output_valid && machine_output_ready) xfers <= xfers + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input string p);
    for (int i = 0; i < p.len(); i++) begin
      @(negedge clk);
      prog_wr_en   = 1'b1;
      prog_wr_addr = 6'(i);
      case (p[i])
        "+": prog_wr_data = 3'd0;
        "-": prog_wr_data = 3'd1;
        ">": prog_wr_data = 3'd2;
        "<": prog_wr_data = 3'd3;
        ".": prog_wr_data = 3'd4;
        ",": prog_wr_data = 3'd5;
        "[": prog_wr_data = 3'd6;
        "]": prog_wr_data = 3'd7;
        default: prog_wr_data = 3'd0;
      endcase
    end
    @(negedge clk);
    prog_wr_en = 1'b0;
    prog_len   = 7'(p.len());
  endtask

  task automatic run_start(input string tag);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy"}, {30'd0, busy, halted}, 32'h2);
  endtask

  task automatic expect_out(input string tag, input logic [7:0] exp);
    int n = 0;
    while (!machine_output_valid && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, {31'd0, machine_output_valid}, 32'h1);
    chk(tag, {24'd0, machine_output}, {24'd0, exp});
    @(negedge clk);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!machine_input_ready && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, {31'd0, machine_input_ready}, 32'h1);
  endtask

  task automatic give_input(input logic [7:0] v);
    machine_input       = v;
    machine_input_valid = 1'b1;
    @(negedge clk);
    machine_input_valid = 1'b0;
  endtask

  // exp_flags is {halted, error, busy}.
  task automatic expect_end(input string tag, input logic [2:0] exp_flags);
    int n = 0;
    while (!halted && !error && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {29'd0, halted, error, busy}, {29'd0, exp_flags});
  endtask

  initial begin
    int    x0;
    logic  stable;
    logic [7:0] held;
    string s;

    rst_n = 1'b0; prog_wr_en = 1'b0; prog_wr_addr = '0; prog_wr_data = '0;
    prog_len = '0; start = 1'b0; machine_input = '0; machine_input_valid = 1'b0;
    machine_output_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_flags", {27'd0, busy, halted, error, machine_output_valid, machine_input_ready}, 32'h0);
    chk("reset_data", {24'd0, machine_output}, 32'h0);
    rst_n = 1'b1;

    // "+++." outputs 3 then halts.
    load("+++.");
    x0 = xfers;
    run_start("p3");
    expect_out("p3_out", 8'h03);
    expect_end("p3_halt", 3'b100);
    chk("p3_xfers", xfers - x0, 32'd1);

    // "-." wraps 0 down to 0xFF.
    load("-.");
    run_start("dec");
    expect_out("dec_out", 8'hFF);
    expect_end("dec_halt", 3'b100);

    // Pointer wraps both ways on a 5-cell tape; second '.' reads cell 4.
    load("<+>.<.");
    run_start("wrap");
    expect_out("wrap_c0", 8'h00);
    expect_out("wrap_c4", 8'h01);
    expect_end("wrap_halt", 3'b100);

    // Nested loop with input.
    load("+[,[.-]+]");
    x0 = xfers;
    run_start("loop");
    wait_ready("loop_in1");
    give_input(8'h02);
    expect_out("loop_out1", 8'h02);
    expect_out("loop_out2", 8'h01);
    wait_ready("loop_in2");
    give_input(8'h00);
    wait_ready("loop_in3");
    stable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      stable = stable & machine_input_ready & busy;
    end
    chk("loop_ready_held", {31'd0, stable}, 32'h1);
    chk("loop_xfers", xfers - x0, 32'd2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Output stall: sink not ready for 10 cycles.
    load("++.");
    machine_output_ready = 1'b0;
    x0 = xfers;
    run_start("stall");
    expect_out("stall_first", 8'h02);
    held = machine_output;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      stable = stable & machine_output_valid & (machine_output == held) & busy;
    end
    chk("stall_stable", {31'd0, stable}, 32'h1);
    chk("stall_no_xfer", xfers - x0, 32'd0);
    machine_output_ready = 1'b1;
    expect_end("stall_halt", 3'b100);
    chk("stall_xfers", xfers - x0, 32'd1);
    chk("stall_valid_low", {31'd0, machine_output_valid}, 32'h0);

    // Unmatched '[' runs off the end of the program.
    load("[");
    run_start("jz_end");
    expect_end("jz_end_err", 3'b010);

    // Unmatched ']' would step below address 0.
    load("+]");
    run_start("jnz_under");
    expect_end("jnz_under_err", 3'b010);

    // Fifteen nested levels is the deepest legal skip.
    s = "";
    for (int i = 0; i < 15; i++) s = {s, "["};
    for (int i = 0; i < 15; i++) s = {s, "]"};
    load(s);
    run_start("depth15");
    expect_end("depth15_halt", 3'b100);

    // Sixteen nested levels exceeds the tracked depth.
    s = "";
    for (int i = 0; i < 16; i++) s = {s, "["};
    for (int i = 0; i < 16; i++) s = {s, "]"};
    load(s);
    run_start("depth16");
    expect_end("depth16_err", 3'b010);

    // Program writes while running are ignored.
    load(",.");
    run_start("wr_busy");
    wait_ready("wr_busy_in");
    prog_wr_en = 1'b1; prog_wr_addr = 6'd1; prog_wr_data = 3'd0;
    @(negedge clk);
    prog_wr_en = 1'b0;
    give_input(8'h5A);
    expect_out("wr_busy_out", 8'h5A);
    expect_end("wr_busy_halt", 3'b100);

    // Reset during an input stall drops ready at once; program survives.
    run_start("rst_in");
    wait_ready("rst_in_wait");
    rst_n = 1'b0;
    #1;
    chk("rst_in_flags", {29'd0, machine_input_ready, busy, halted}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_idle", {29'd0, busy, halted, error}, 32'h0);
    run_start("rerun");
    wait_ready("rerun_in");
    give_input(8'h37);
    expect_out("rerun_out", 8'h37);
    expect_end("rerun_halt", 3'b100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
